redop_stream: RTL and testbench
===============================

// Module: redop_stream
// PURPOSE
//  Streaming, multi-mode bitwise reduction unit; successor to the single-word combinational OR-reduce.
//  Reduces a packet of one or more WIDTH-bit beats (OR / AND / XOR) to a 1-bit result, plus beat count
//  and index of first "hit" beat. Sits between activation buffers and non-linear op control (zero/sat
//  detection over a whole tensor row). Valid/ready on both sides; one registered result per packet.
// PARAMETERS
//  WIDTH   64  bits per input beat (>=1)
//  CNTW    16  width of beat counter and hit index (>=1)
// PORTS
//  clk             in   1      clock, all state updates on rising edge
//  rst             in   1      synchronous reset, active-high
//  redop_mode_i    in   2      0=OR 1=AND 2=XOR 3=reserved(treated as OR); sampled on first beat only
//  redop_vld_i     in   1      input beat valid
//  redop_rdy_o     out  1      input beat ready
//  redop_i1        in   WIDTH  input beat data
//  redop_last_i    in   1      beat is last of packet
//  redop_vld_o     out  1      result valid
//  redop_rdy_i     in   1      result ready (downstream)
//  redop_o         out  1      packet reduction result
//  redop_cnt_o     out  CNTW   number of beats in packet (saturating)
//  redop_hit_o     out  1      a hit beat occurred in packet
//  redop_hitidx_o  out  CNTW   0-based index of first hit beat (0 if none)
// BEHAVIOUR
//  - Beat accepted when redop_vld_i & redop_rdy_o. redop_rdy_o = ~redop_vld_o | redop_rdy_i (comb).
//  - Per-beat value b: OR=|data, AND=&data, XOR=^data. Identity I: OR=0, AND=1, XOR=0.
//  - States: IDLE (no packet open) / ACC (packet open). IDLE->ACC on accepted non-last beat;
//    ACC->IDLE on accepted last beat. Single-beat packet (last on first beat): stays IDLE.
//  - First beat (in IDLE): latch mode; acc=b; cnt=1; hit=(b!=I); hitidx=0.
//  - Later beats (in ACC): acc=acc op b using latched mode; cnt=cnt+1 saturating at 2^CNTW-1;
//    if !hit & b!=I: hit=1, hitidx=cnt (pre-increment value, saturated). Mode input ignored.
//  - On accepted last beat: next cycle redop_vld_o=1 with redop_o/cnt/hit/hitidx of the complete
//    packet (including last beat). Latency: 1 cycle from last-beat acceptance to valid.
//  - Output holds stable while redop_vld_o & ~redop_rdy_i. Cleared on handshake unless a new last beat
//    accepted same cycle (back-to-back: vld_o stays 1, new result loaded). Throughput 1 beat/cycle.
//  - Stall: while output held, no beats accepted (including non-last), input state frozen.
//  - Counter saturation: cnt_o stays 2^CNTW-1 beyond limit; hitidx saturates identically.
//  - Reset: redop_vld_o=0, redop_o=0, cnt_o=0, hit_o=0, hitidx_o=0, state=IDLE, acc/mode cleared;
//    reset mid-packet discards partial packet; redop_rdy_o=1 first cycle after reset.
//  - Data/last/mode are don't-care when redop_vld_i=0. Outputs don't-care content rules only apply
//    when redop_vld_o=1, but must still follow reset values.
// TESTING
//  1 OR, 1 beat 0x0 last -> next cycle vld_o=1, o=0, cnt=1, hit=0, hitidx=0.
//  2 OR, beats {0,0,0x80,0} last on 4th -> o=1, cnt=4, hit=1, hitidx=2.
//  3 AND, beats {all1, all1 except bit5, all1} -> o=0, cnt=3, hit=1, hitidx=1; mode driven 0 on beats
//    2-3 ignored.
//  4 XOR, beats {0x1,0x3,0x1} -> o=0 (1^0^1), cnt=3, hit=1, hitidx=0.
//  5 Backpressure: rdy_i=0 for 5 cycles with result pending -> rdy_o=0, outputs stable; then rdy_i=1
//    with next last beat same cycle -> vld_o stays 1, new result next cycle, no beat lost.
//  6 CNTW=2, 6-beat OR packet, hit on beat 5 -> cnt=3, hitidx=3; rst asserted after beat 2 of next
//    packet -> vld_o=0, next packet counts from 1.

Source files
------------

// File: rtl/redop_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : redop_stream_if
// Brief    : Valid/ready beat input and result output bundle for redop_stream
// Revision : 1.0 - initial release
// ============================================================================
interface redop_stream_if #(
    parameter int WIDTH = 64,
    parameter int CNTW  = 16
);
    // Upstream beat channel
    logic [1:0]       redop_mode_i;
    logic             redop_vld_i;
    logic             redop_rdy_o;
    logic [WIDTH-1:0] redop_i1;
    logic             redop_last_i;
    // Downstream result channel
    logic             redop_vld_o;
    logic             redop_rdy_i;
    logic             redop_o;
    logic [CNTW-1:0]  redop_cnt_o;
    logic             redop_hit_o;
    logic [CNTW-1:0]  redop_hitidx_o;

    // Producer/consumer side (drives beats, accepts results)
    modport master (
        output redop_mode_i, redop_vld_i, redop_i1, redop_last_i, redop_rdy_i,
        input  redop_rdy_o, redop_vld_o, redop_o, redop_cnt_o, redop_hit_o, redop_hitidx_o
    );

    // Reduction unit side
    modport slave (
        input  redop_mode_i, redop_vld_i, redop_i1, redop_last_i, redop_rdy_i,
        output redop_rdy_o, redop_vld_o, redop_o, redop_cnt_o, redop_hit_o, redop_hitidx_o
    );
endinterface
`default_nettype wire

// File: rtl/redop_stream.sv
`default_nettype none
// ============================================================================
// Module   : redop_stream
// Brief    : Streaming OR/AND/XOR packet reduction with beat count and index
//            of the first beat that differs from the reduction identity
// Revision : 1.0 - initial release
// ============================================================================
module redop_stream #(
    parameter int WIDTH = 64,
    parameter int CNTW  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    redop_stream_if.slave     bus
);
    localparam logic [1:0]      c_mode_or  = 2'd0;
    localparam logic [1:0]      c_mode_and = 2'd1;
    localparam logic [1:0]      c_mode_xor = 2'd2;
    localparam logic [0:0]      c_st_idle  = 1'b0;
    localparam logic [0:0]      c_st_acc   = 1'b1;
    localparam logic [CNTW-1:0] c_cnt_max  = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] c_cnt_one  = CNTW'(1);

    logic [0:0]      r_state;
    logic [1:0]      r_mode;
    logic            r_acc;
    logic [CNTW-1:0] r_cnt;
    logic            r_hit;
    logic [CNTW-1:0] r_hitidx;

    logic            r_vld_o;
    logic            r_res_o;
    logic [CNTW-1:0] r_cnt_o;
    logic            r_hit_o;
    logic [CNTW-1:0] r_hitidx_o;

    logic            w_rdy;
    logic            w_accept;
    logic            w_in_idle;
    logic [1:0]      w_mode_in;
    logic [1:0]      w_mode;
    logic            w_b;
    logic            w_ident;
    logic            w_hit_beat;
    logic            w_acc_n;
    logic [CNTW-1:0] w_cnt_n;
    logic            w_hit_n;
    logic [CNTW-1:0] w_hitidx_n;

    // Input is blocked only while a result is waiting for a downstream that is not ready
    assign w_rdy      = ~r_vld_o | bus.redop_rdy_i;
    assign w_accept   = bus.redop_vld_i & w_rdy;
    assign w_in_idle  = (r_state == c_st_idle);
    // Reserved encoding behaves as OR; the mode is only honoured on the first beat
    assign w_mode_in  = (bus.redop_mode_i == 2'd3) ? c_mode_or : bus.redop_mode_i;
    assign w_mode     = w_in_idle ? w_mode_in : r_mode;
    assign w_hit_beat = (w_b != w_ident);

    // Per-beat reduction value and the identity element of the active mode
    always_comb begin
        w_b     = |bus.redop_i1;
        w_ident = 1'b0;
        case (w_mode)
            c_mode_and: begin
                w_b     = &bus.redop_i1;
                w_ident = 1'b1;
            end
            c_mode_xor: begin
                w_b     = ^bus.redop_i1;
                w_ident = 1'b0;
            end
            default: begin
                w_b     = |bus.redop_i1;
                w_ident = 1'b0;
            end
        endcase
    end

    // Packet state after folding in the current beat
    always_comb begin
        w_acc_n    = r_acc;
        w_cnt_n    = r_cnt;
        w_hit_n    = r_hit;
        w_hitidx_n = r_hitidx;
        if (w_in_idle) begin
            w_acc_n    = w_b;
            w_cnt_n    = c_cnt_one;
            w_hit_n    = w_hit_beat;
            w_hitidx_n = '0;
        end else begin
            case (r_mode)
                c_mode_and: w_acc_n = r_acc & w_b;
                c_mode_xor: w_acc_n = r_acc ^ w_b;
                default:    w_acc_n = r_acc | w_b;
            endcase
            w_cnt_n = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;
            // r_cnt is the pre-increment, already saturated index of this beat
            if (!r_hit && w_hit_beat) begin
                w_hit_n    = 1'b1;
                w_hitidx_n = r_cnt;
            end
        end
    end

    // Packet accumulation, IDLE/ACC sequencing and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_mode     <= c_mode_or;
            r_acc      <= 1'b0;
            r_cnt      <= '0;
            r_hit      <= 1'b0;
            r_hitidx   <= '0;
            r_vld_o    <= 1'b0;
            r_res_o    <= 1'b0;
            r_cnt_o    <= '0;
            r_hit_o    <= 1'b0;
            r_hitidx_o <= '0;
        end else begin
            if (r_vld_o && bus.redop_rdy_i) begin
                r_vld_o <= 1'b0;
            end
            if (w_accept) begin
                if (w_in_idle) begin
                    r_mode <= w_mode_in;
                end
                r_acc    <= w_acc_n;
                r_cnt    <= w_cnt_n;
                r_hit    <= w_hit_n;
                r_hitidx <= w_hitidx_n;
                if (bus.redop_last_i) begin
                    r_state    <= c_st_idle;
                    r_vld_o    <= 1'b1;
                    r_res_o    <= w_acc_n;
                    r_cnt_o    <= w_cnt_n;
                    r_hit_o    <= w_hit_n;
                    r_hitidx_o <= w_hitidx_n;
                end else begin
                    r_state <= c_st_acc;
                end
            end
        end
    end

    assign bus.redop_rdy_o    = w_rdy;
    assign bus.redop_vld_o    = r_vld_o;
    assign bus.redop_o        = r_res_o;
    assign bus.redop_cnt_o    = r_cnt_o;
    assign bus.redop_hit_o    = r_hit_o;
    assign bus.redop_hitidx_o = r_hitidx_o;
endmodule
`default_nettype wire

// File: tb/tb_redop_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_redop_stream
// Brief    : Directed-vector bench for redop_stream (wide and narrow counter)
// Revision : 1.0 - initial release
// ============================================================================
module tb_redop_stream;
    localparam int c_wa = 64;
    localparam int c_ca = 16;
    localparam int c_wb = 8;
    localparam int c_cb = 2;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    redop_stream_if #(.WIDTH(c_wa), .CNTW(c_ca)) a_if ();
    redop_stream_if #(.WIDTH(c_wb), .CNTW(c_cb)) b_if ();

    redop_stream #(.WIDTH(c_wa), .CNTW(c_ca)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    redop_stream #(.WIDTH(c_wb), .CNTW(c_cb)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector and reports miscompares
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res_a(input string tag, input logic vld, input logic res,
                               input logic [15:0] cnt, input logic hit, input logic [15:0] idx);
        check_val({tag, "_vld"},    64'(a_if.redop_vld_o),    64'(vld));
        check_val({tag, "_o"},      64'(a_if.redop_o),        64'(res));
        check_val({tag, "_cnt"},    64'(a_if.redop_cnt_o),    64'(cnt));
        check_val({tag, "_hit"},    64'(a_if.redop_hit_o),    64'(hit));
        check_val({tag, "_hitidx"}, 64'(a_if.redop_hitidx_o), 64'(idx));
    endtask

    task automatic check_res_b(input string tag, input logic vld, input logic res,
                               input logic [1:0] cnt, input logic hit, input logic [1:0] idx);
        check_val({tag, "_vld"},    64'(b_if.redop_vld_o),    64'(vld));
        check_val({tag, "_o"},      64'(b_if.redop_o),        64'(res));
        check_val({tag, "_cnt"},    64'(b_if.redop_cnt_o),    64'(cnt));
        check_val({tag, "_hit"},    64'(b_if.redop_hit_o),    64'(hit));
        check_val({tag, "_hitidx"}, 64'(b_if.redop_hitidx_o), 64'(idx));
    endtask

    // Present one beat on A and return #1 after the edge that accepted it
    task automatic beat_a(input logic [1:0] mode, input logic [63:0] data, input logic last);
        int n;
        a_if.redop_mode_i = mode;
        a_if.redop_i1     = data;
        a_if.redop_last_i = last;
        a_if.redop_vld_i  = 1'b1;
        @(negedge clk);
        n = 0;
        while (!a_if.redop_rdy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_if.redop_rdy_o) check_val("a_rdy_timeout", 64'(a_if.redop_rdy_o), 64'd1);
        @(posedge clk);
        #1;
        a_if.redop_vld_i  = 1'b0;
        a_if.redop_last_i = 1'b0;
    endtask

    task automatic beat_b(input logic [7:0] data, input logic last);
        int n;
        b_if.redop_mode_i = 2'd0;
        b_if.redop_i1     = data;
        b_if.redop_last_i = last;
        b_if.redop_vld_i  = 1'b1;
        @(negedge clk);
        n = 0;
        while (!b_if.redop_rdy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!b_if.redop_rdy_o) check_val("b_rdy_timeout", 64'(b_if.redop_rdy_o), 64'd1);
        @(posedge clk);
        #1;
        b_if.redop_vld_i  = 1'b0;
        b_if.redop_last_i = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        a_if.redop_mode_i = 2'd0; a_if.redop_vld_i = 1'b0; a_if.redop_i1 = '0;
        a_if.redop_last_i = 1'b0; a_if.redop_rdy_i = 1'b1;
        b_if.redop_mode_i = 2'd0; b_if.redop_vld_i = 1'b0; b_if.redop_i1 = '0;
        b_if.redop_last_i = 1'b0; b_if.redop_rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_res_a("rst_a", 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
        check_val("rst_a_rdy", 64'(a_if.redop_rdy_o), 64'd1);
        check_res_b("rst_b", 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);

        // 1: OR, single zero beat
        beat_a(2'd0, 64'h0, 1'b1);
        check_res_a("t1", 1'b1, 1'b0, 16'd1, 1'b0, 16'd0);

        // 2: OR, hit on third beat
        beat_a(2'd0, 64'h0,  1'b0);
        check_val("t2_no_early_vld", 64'(a_if.redop_vld_o), 64'd0);
        beat_a(2'd0, 64'h0,  1'b0);
        beat_a(2'd0, 64'h80, 1'b0);
        beat_a(2'd0, 64'h0,  1'b1);
        check_res_a("t2", 1'b1, 1'b1, 16'd4, 1'b1, 16'd2);

        // 3: AND, second beat has bit 5 clear; mode input changes are ignored mid-packet
        beat_a(2'd1, {64{1'b1}},  1'b0);
        beat_a(2'd0, ~64'h20,     1'b0);
        beat_a(2'd0, {64{1'b1}},  1'b1);
        check_res_a("t3", 1'b1, 1'b0, 16'd3, 1'b1, 16'd1);

        // 4: XOR, parities 1,0,1
        beat_a(2'd2, 64'h1, 1'b0);
        beat_a(2'd2, 64'h3, 1'b0);
        beat_a(2'd2, 64'h1, 1'b1);
        check_res_a("t4", 1'b1, 1'b0, 16'd3, 1'b1, 16'd0);

        // 5: backpressure with a pending result and a waiting last beat
        beat_a(2'd3, 64'h1, 1'b1);                 // reserved mode acts as OR
        check_res_a("t5_first", 1'b1, 1'b1, 16'd1, 1'b1, 16'd0);
        a_if.redop_rdy_i  = 1'b0;
        a_if.redop_mode_i = 2'd0;
        a_if.redop_i1     = 64'h0;
        a_if.redop_last_i = 1'b1;
        a_if.redop_vld_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t5_stall_rdy", 64'(a_if.redop_rdy_o), 64'd0);
            check_res_a("t5_hold", 1'b1, 1'b1, 16'd1, 1'b1, 16'd0);
        end
        a_if.redop_rdy_i = 1'b1;
        @(posedge clk);
        #1;
        a_if.redop_vld_i  = 1'b0;
        a_if.redop_last_i = 1'b0;
        check_res_a("t5_next", 1'b1, 1'b0, 16'd1, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        check_val("t5_drain_vld", 64'(a_if.redop_vld_o), 64'd0);

        // 6: narrow counter saturation, hit on beat 5
        beat_b(8'h0, 1'b0);
        beat_b(8'h0, 1'b0);
        beat_b(8'h0, 1'b0);
        beat_b(8'h0, 1'b0);
        beat_b(8'h4, 1'b0);
        beat_b(8'h0, 1'b1);
        check_res_b("t6_sat", 1'b1, 1'b1, 2'd3, 1'b1, 2'd3);

        // 6: reset mid-packet discards the partial packet
        beat_b(8'h1, 1'b0);
        beat_b(8'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("t6_rst_vld", 64'(b_if.redop_vld_o), 64'd0);
        check_val("t6_rst_rdy", 64'(b_if.redop_rdy_o), 64'd1);
        beat_b(8'h0, 1'b0);
        beat_b(8'h0, 1'b1);
        check_res_b("t6_after_rst", 1'b1, 1'b0, 2'd2, 1'b0, 2'd0);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
